// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct codes, FSM encoding and decode helpers for the EX-stage HI/LO unit.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_div(input logic [5:0] f);
    return (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == F_MULT) || (f == F_DIV);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: iterative 32-step shift-add multiplier / restoring divider on operand magnitudes.
// Latency: one step per cycle with step high; sign-corrected result is combinational from the accumulator.
// Backpressure: none; the controlling FSM decides when to load and step.
// Ports: clk/rst (async active-low); load latches op/a/b; step advances one iteration;
//        res_hi/res_lo carry the final HI/LO values once 32 steps have run.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic        div_q;   // operation is a divide
  logic        neg_q;   // product / quotient must be negated
  logic        rneg_q;  // remainder takes the dividend's sign
  logic        zero_q;  // divisor was zero
  logic [31:0] a_q;     // original dividend, returned in HI on divide-by-zero
  logic [31:0] b_q;     // multiplicand / divisor magnitude
  logic [63:0] acc_q;   // {upper, lower}: product or {remainder, quotient}
  logic [63:0] acc_d;
  logic [32:0] sum;
  logic [32:0] diff;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        op_sgn;

  assign op_sgn = is_signed_op(op);

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else if (load) begin
      div_q  <= is_div(op);
      neg_q  <= op_sgn && (a[31] ^ b[31]);
      rneg_q <= op_sgn && a[31];
      zero_q <= (b == 32'd0);
      a_q    <= a;
      b_q    <= mag(b, op_sgn);
      acc_q  <= {32'd0, mag(a, op_sgn)};
    end else if (step) begin
      acc_q  <= acc_d;
    end
  end

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set,
  // then shift the 65-bit {carry, upper, lower} right.
  // Divide: shift {remainder, dividend} left and keep the trial subtraction if it
  // does not borrow; the freed LSB collects the quotient bit.
  always_comb begin
    sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    diff = acc_q[63:31] - {1'b0, b_q};
    if (div_q) begin
      acc_d = diff[32] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_d = {sum, acc_q[31:1]};
    end
  end

  assign prod = neg_q  ? (64'd0 - acc_q)         : acc_q;
  assign quo  = neg_q  ? (32'd0 - acc_q[31:0])   : acc_q[31:0];
  assign rem  = rneg_q ? (32'd0 - acc_q[63:32])  : acc_q[63:32];

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (div_q) begin
      if (zero_q) begin
        res_hi = a_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage HI/LO unit -- MULT/MULTU/DIV/DIVU, MTHI/MTLO writes, MFHI/MFLO reads.
// Latency: mul/div writes HI/LO 33 edges after acceptance, done the cycle after; MT* same edge; MF* combinational.
// Backpressure: stall = start && busy; a start while busy waits for IDLE; flush aborts to IDLE.
// Ports: clk/rst (async active-low); start/funct/rd1/rd2 from EX; flush squashes the operation;
//        stall/busy/done status; hi/lo architectural registers; result is MFHI/MFLO read data.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        dp_load;
  logic        dp_step;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  muldiv_datapath u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (dp_load),
    .step   (dp_step),
    .op     (funct),
    .a      (rd1),
    .b      (rd2),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && is_muldiv(funct)) begin
          dp_load = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        dp_step = 1'b1;
        // 32nd step: counter wraps 31 -> 0 on this edge
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // squash wins over everything, including a same-cycle start
    if (flush) begin
      state_d = IDLE;
      dp_load = 1'b0;
      dp_step = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (dp_load || flush) cnt_q <= '0;
      else if (dp_step)     cnt_q <= cnt_q + 5'd1;
      if (!flush) begin
        if (state_q == FIX) begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end else if (state_q == IDLE && start) begin
          if (funct == F_MTHI) hi <= rd1;
          if (funct == F_MTLO) lo <= rd1;
        end
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = start && busy;

  always_comb begin
    result = 32'd0;
    if (funct == F_MFHI) result = hi;
    if (funct == F_MFLO) result = lo;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] rd1   = 32'd0;
  logic [31:0] rd2   = 32'd0;
  logic        stall, busy, done;
  logic [31:0] hi, lo, result;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_hi   = 32'd0;
  logic [31:0] exp_lo   = 32'd0;

  ex_muldiv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct  (funct),
    .rd1    (rd1),
    .rd2    (rd2),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural reference: {HI, LO} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 64'd0;
    case (f)
      F_MULT:  res = sa * sb;
      F_MULTU: res = {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = {exp_hi, exp_lo};
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] e;
    int lat;
    e = ref_op(f, a, b);
    start = 1'b1; funct = f; rd1 = a; rd2 = b;
    #1;
    check({tag, " stall_at_issue"}, 64'(stall), 64'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, " busy_after_T0"}, 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
    end
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    check({tag, " done_latency"}, 64'(lat), 64'd33);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic do_mt(input logic [5:0] f, input logic [31:0] v);
    start = 1'b1; funct = f; rd1 = v;
    #1;
    check("mt stall", 64'(stall), 64'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (f == F_MTHI) exp_hi = v; else exp_lo = v;
    funct = F_MFHI;
    #1;
    check("mt mfhi result", 64'(result), 64'(exp_hi));
    funct = F_MFLO;
    #1;
    check("mt mflo result", 64'(result), 64'(exp_lo));
  endtask

  initial begin
    int lat, bad, saw;
    logic [5:0] f;

    // reset state while rst is low, even with a start presented
    start = 1'b1; funct = F_MULT;
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // MULT 7 * -3, then an MFHI in the done cycle
    run_op(F_MULT, 32'd7, 32'hFFFF_FFFD, "mult7x-3");
    check("mult done", 64'(done), 64'd1);
    start = 1'b1; funct = F_MFHI;
    #1;
    check("donecycle stall", 64'(stall), 64'd0);
    check("donecycle mfhi", 64'(result), 64'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("done one pulse", 64'(done), 64'd0);

    run_op(F_DIVU, 32'd100, 32'd7, "divu100/7");
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, "div-7/2");
    run_op(F_DIV, 32'h1234_5678, 32'd0, "div/0");
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

    // MTHI then back-to-back MFHI
    @(negedge clk);
    start = 1'b1; funct = F_MTHI; rd1 = 32'hAAAA_5555;
    #1;
    check("mthi stall", 64'(stall), 64'd0);
    @(negedge clk);
    exp_hi = 32'hAAAA_5555;
    funct = F_MFHI;
    #1;
    check("mfhi stall", 64'(stall), 64'd0);
    check("mthi hi", 64'(hi), 64'hAAAA_5555);
    check("mfhi result", 64'(result), 64'hAAAA_5555);
    @(negedge clk);
    start = 1'b0;

    // flush in the 10th RUN cycle of a MULT
    start = 1'b1; funct = F_MULT; rd1 = 32'h1234_5678; rd2 = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi", 64'(hi), 64'(exp_hi));
    check("flush lo", 64'(lo), 64'(exp_lo));
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    check("flush no done", 64'(saw), 64'd0);

    // flush beats a same-cycle start (MTLO and MULT)
    start = 1'b1; flush = 1'b1; funct = F_MTLO; rd1 = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    check("flush>mtlo lo", 64'(lo), 64'(exp_lo));
    funct = F_MULT;
    @(negedge clk);
    #1;
    check("flush>mult busy", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);

    // MFLO held during a MULT: stall until IDLE, then fresh LO visible
    begin
      logic [63:0] e;
      e = ref_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      start = 1'b1; funct = F_MULTU; rd1 = 32'hFFFF_FFFF; rd2 = 32'hFFFF_FFFF;
      @(negedge clk);
      funct = F_MFLO;
      #1;
      lat = 0; bad = 0;
      while (busy && lat < 40) begin
        if (!stall) bad++;
        @(negedge clk);
        #1;
        lat++;
      end
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      check("mflo stall held", 64'(bad), 64'd0);
      check("mflo wait", 64'(lat), 64'd33);
      check("mflo done", 64'(done), 64'd1);
      check("mflo stall idle", 64'(stall), 64'd0);
      check("mflo result", 64'(result), 64'(exp_lo));
      start = 1'b0;
    end
    @(negedge clk);

    // reset asserted at cycle 20 of a DIV
    start = 1'b1; funct = F_DIV; rd1 = 32'h7654_3210; rd2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw = 1;
    end
    check("midreset no done", 64'(saw), 64'd0);

    // randomized back-to-back traffic against the reference
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       f = F_MULT;
        1:       f = F_MULTU;
        2:       f = F_DIV;
        3:       f = F_DIVU;
        4:       f = F_MTHI;
        default: f = F_MTLO;
      endcase
      if (f == F_MTHI || f == F_MTLO) do_mt(f, pick_val());
      else run_op(f, pick_val(), pick_val(), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, the EX-stage instruction is a HI/LO operation, valid this cycle.
REQ-004 SHALL have port funct, input, 6, EX-stage funct field; codes 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO.
REQ-005 SHALL have port rd1, input, 32, forwarded rs operand.
REQ-006 SHALL have port rd2, input, 32, forwarded rt operand.
REQ-007 SHALL have port flush, input, 1, abort the in-flight operation (branch or exception squash).
REQ-008 SHALL have port stall, output, 1, hold IF/ID/EX; the EX instruction cannot complete this cycle.
REQ-009 SHALL have port busy, output, 1, unit not IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when HI/LO take a MULT/DIV result.
REQ-011 SHALL have ports hi and lo, output, 32 each, architectural HI and LO registers.
REQ-012 SHALL have port result, output, 32, MFHI/MFLO read data for the EX result mux.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-014 SHALL, in IDLE with start and a MULT/MULTU/DIV/DIVU funct, latch operands, clear a 5-bit iteration counter and enter RUN at that edge (T0).
REQ-015 SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per RUN cycle on operand magnitudes; signed ops use absolute values.
REQ-016 SHALL leave RUN for FIX after exactly 32 iterations (counter wraps 31->0), i.e. at edge T0+32.
REQ-017 SHALL, in FIX, apply sign correction and write HI/LO at edge T0+33, then return to IDLE with done high for the following cycle only.
REQ-018 SHALL produce for multiply a 64-bit product: HI = upper 32 bits, LO = lower 32 bits.
REQ-019 SHALL produce for divide LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-020 SHALL, when the divisor is 0, write LO = 0xFFFFFFFF and HI = dividend.
REQ-021 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, write LO = 0x80000000 and HI = 0.
REQ-022 SHALL, in IDLE with start and MTHI or MTLO, write rd1 into HI or LO at that edge with no stall.
REQ-023 SHALL drive result = hi for MFHI and result = lo for MFLO, combinationally.
REQ-024 SHALL drive stall = start && busy; a start arriving while busy is ignored until IDLE (MF/MT/MULT/DIV alike).
REQ-025 SHALL, in the cycle done is high, accept a new start normally, with result reflecting the new HI/LO.
REQ-026 SHALL, on flush in any state, return to IDLE at the next edge with HI/LO unchanged and no done pulse; flush has priority over start in the same cycle.

Reset
REQ-027 SHALL, while rst is low, force state = IDLE, hi = lo = 0, counter = 0, done = 0 and busy = 0, regardless of clk.
REQ-028 SHALL, on reset asserted mid-operation, discard the operation with no later done pulse.

Structure
REQ-029 SHALL take the funct code constants and the state encoding from a shared package, muldiv_pkg.
REQ-030 SHALL place the iterative shift/subtract datapath in one sub-module, muldiv_datapath; the FSM, HI/LO and stall logic stay in ex_muldiv.

Verification
REQ-031 SHALL cover MULT with rd1 = 7, rd2 = 0xFFFFFFFD: expect hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, and done in the cycle after edge T0+33.
REQ-032 SHALL cover DIVU 100/7 -> lo = 14, hi = 2; and DIV 0xFFFFFFF9/2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-033 SHALL cover DIV with rd2 = 0 and rd1 = 0x12345678: expect lo = 0xFFFFFFFF, hi = 0x12345678.
REQ-034 SHALL cover MTHI 0xAAAA5555 followed by a back-to-back MFHI: expect hi and result = 0xAAAA5555, stall never high.
REQ-035 SHALL cover flush at cycle 10 of a MULT: expect IDLE next cycle, HI/LO unchanged, no done; and a MFLO during RUN: expect stall held high until IDLE.
REQ-036 SHALL cover rst pulled low at cycle 20 of a DIV: expect immediate hi = lo = 0, busy = 0, and no done after release.
